// File: rtl/dvp_tx.sv
// dvp_tx: DVP stream source. Generates frame timing and serialises 24-bit RGB
// pixels, pulled through a valid/ready handshake, as R,G,B bytes, one per clock.
module dvp_tx #(
  parameter int unsigned H_ACTIVE      = 1280,
  parameter int unsigned H_TOTAL       = 1650,
  parameter int unsigned V_ACTIVE      = 720,
  parameter int unsigned V_FRONT       = 5,
  parameter int unsigned VSYNC_LINES   = 5,
  parameter int unsigned V_TOTAL       = 750,
  parameter logic [23:0] UNDERFLOW_RGB = 24'h000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [23:0] pixel_rgb,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  output logic [11:0] x,
  output logic [10:0] y,
  output logic        dvp_vsync,
  output logic        dvp_de,
  output logic [7:0]  dvp_data,
  output logic        frame_start,
  output logic        underflow
);

  localparam int unsigned XW = 12;
  localparam int unsigned YW = 11;

  localparam logic [XW-1:0] X_ACT  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] Y_ACT  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] VS_BEG = YW'(V_ACTIVE + V_FRONT);
  localparam logic [YW-1:0] VS_END = YW'(V_ACTIVE + V_FRONT + VSYNC_LINES);

  logic [1:0]  phase;
  logic        active;
  logic        vs;
  logic        first_slot;
  logic [23:0] pix_in;
  logic [23:0] pix_hold;

  // Region decode and pixel selection from the current counter state
  always_comb begin
    active      = (x < X_ACT) && (y < Y_ACT);
    vs          = (y >= VS_BEG) && (y < VS_END);
    first_slot  = (x == '0) && (y == '0) && (phase == 2'd0);
    pix_in      = pixel_valid ? pixel_rgb : UNDERFLOW_RGB;
    // rst_n gating keeps ready low while reset holds the counters at zero
    pixel_ready = rst_n && en && active && (phase == 2'd0);
  end

  // Byte phase, pixel slot and line counters; en low restarts the frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 2'd0;
      x     <= '0;
      y     <= '0;
    end else if (!en) begin
      phase <= 2'd0;
      x     <= '0;
      y     <= '0;
    end else if (phase != 2'd2) begin
      phase <= phase + 2'd1;
    end else begin
      phase <= 2'd0;
      if (x != X_LAST) begin
        x <= x + XW'(1);
      end else begin
        x <= '0;
        y <= (y != Y_LAST) ? y + YW'(1) : '0;
      end
    end
  end

  // Registered DVP outputs, one cycle behind the counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvp_de      <= 1'b0;
      dvp_vsync   <= 1'b0;
      dvp_data    <= 8'h00;
      frame_start <= 1'b0;
      pix_hold    <= 24'h000000;
    end else if (!en) begin
      dvp_de      <= 1'b0;
      dvp_vsync   <= 1'b0;
      dvp_data    <= 8'h00;
      frame_start <= 1'b0;
    end else begin
      dvp_de      <= active;
      dvp_vsync   <= vs;
      frame_start <= first_slot;
      if (pixel_ready) begin
        pix_hold <= pix_in;
      end
      if (!active) begin
        dvp_data <= 8'h00;
      end else begin
        unique case (phase)
          2'd0:    dvp_data <= pix_in[23:16];
          2'd1:    dvp_data <= pix_hold[15:8];
          default: dvp_data <= pix_hold[7:0];
        endcase
      end
    end
  end

  // Sticky underflow: set when an active slot finds no valid pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow <= 1'b0;
    end else if (pixel_ready && !pixel_valid) begin
      underflow <= 1'b1;
    end
  end

endmodule
